// File: rtl/conv_scheduler_if.sv
// conv_scheduler_if: control and result bus between the convolution loop scheduler and the
// rest of the single-MAC datapath.
//   start/running/done           : frame control (start in; running, done out of scheduler)
//   int_mem_re, input_addr,
//   kernel_addr                  : read port control for the input and kernel memories
//   write_a, write_b, pad_zero   : operand register loads; pad_zero zeroes operand a
//   mac_valid,
//   mac_accumulate_internal      : MAC input strobe and accumulate-vs-restart select
//   out_valid/out_ready,
//   output_x/_y/_ch              : finished result handshake and its coordinates
// The master modport is the scheduler side; the slave modport is the datapath/consumer side.
interface conv_scheduler_if #(
    parameter int unsigned XW  = 6,
    parameter int unsigned YW  = 7,
    parameter int unsigned ICW = 1,
    parameter int unsigned OCW = 4
);
    logic                   start;
    logic                   running;
    logic                   done;
    logic                   int_mem_re;
    logic [ICW+YW+XW-1:0]   input_addr;
    logic [ICW+4+OCW-1:0]   kernel_addr;
    logic                   write_a;
    logic                   write_b;
    logic                   pad_zero;
    logic                   mac_valid;
    logic                   mac_accumulate_internal;
    logic                   out_valid;
    logic                   out_ready;
    logic [XW-1:0]          output_x;
    logic [YW-1:0]          output_y;
    logic [OCW-1:0]         output_ch;

    modport master (
        input  start, out_ready,
        output running, done, int_mem_re, input_addr, kernel_addr, write_a, write_b,
               pad_zero, mac_valid, mac_accumulate_internal, out_valid,
               output_x, output_y, output_ch
    );

    modport slave (
        output start, out_ready,
        input  running, done, int_mem_re, input_addr, kernel_addr, write_a, write_b,
               pad_zero, mac_valid, mac_accumulate_internal, out_valid,
               output_x, output_y, output_ch
    );
endinterface

// File: rtl/conv_scheduler.sv
// conv_scheduler: loop scheduler for a KERNEL_SIZE x KERNEL_SIZE zero-padded ("same")
// convolution on a single MAC. Walks y, x, outch (outer) and inch, ky, kx (one accumulation),
// issues one operand read per cycle, and pipelines operand-register and MAC control to
// match a 1-cycle memory and a registered MAC. Results are handed off on out_valid/out_ready.
//   clk     : rising-edge clock
//   arst_in : asynchronous reset, active high
//   bus     : conv_scheduler_if master modport (frame control, memory reads, MAC control,
//             result handshake)
module conv_scheduler #(
    parameter int unsigned FEATURE_MAP_WIDTH  = 64,
    parameter int unsigned FEATURE_MAP_HEIGHT = 128,
    parameter int unsigned INPUT_NB_CHANNELS  = 2,
    parameter int unsigned OUTPUT_NB_CHANNELS = 16,
    parameter int unsigned KERNEL_SIZE        = 3
) (
    input  logic             clk,
    input  logic             arst_in,
    conv_scheduler_if.master bus
);
    localparam int unsigned XW  = $clog2(FEATURE_MAP_WIDTH);
    localparam int unsigned YW  = $clog2(FEATURE_MAP_HEIGHT);
    localparam int unsigned ICW = (INPUT_NB_CHANNELS > 1) ? $clog2(INPUT_NB_CHANNELS) : 1;
    localparam int unsigned OCW = $clog2(OUTPUT_NB_CHANNELS);

    localparam logic [1:0]     KMax  = 2'(KERNEL_SIZE - 1);
    localparam logic [XW-1:0]  XMax  = XW'(FEATURE_MAP_WIDTH - 1);
    localparam logic [YW-1:0]  YMax  = YW'(FEATURE_MAP_HEIGHT - 1);
    localparam logic [ICW-1:0] IcMax = ICW'(INPUT_NB_CHANNELS - 1);
    localparam logic [OCW-1:0] OcMax = OCW'(OUTPUT_NB_CHANNELS - 1);
    localparam logic [XW+1:0]  HalfX = (XW + 2)'(KERNEL_SIZE / 2);
    localparam logic [YW+1:0]  HalfY = (YW + 2)'(KERNEL_SIZE / 2);

    typedef enum logic [1:0] {StIdle, StIssue, StWaitOut, StDone} state_e;

    state_e         state_q;
    logic [YW-1:0]  y_q;
    logic [XW-1:0]  x_q;
    logic [OCW-1:0] oc_q;
    logic [ICW-1:0] ic_q;
    logic [1:0]     ky_q;
    logic [1:0]     kx_q;

    logic [XW-1:0]  out_x_q;
    logic [YW-1:0]  out_y_q;
    logic [OCW-1:0] out_ch_q;
    logic           running_q;
    logic           done_q;

    // Stage 1 aligns with the memory read data, stage 2 with the MAC input.
    logic           s1_q;
    logic           pad1_q;
    logic           first1_q;
    logic           last1_q;
    logic           mac_valid_q;
    logic           acc_q;
    logic           last2_q;
    logic           out_valid_q;

    logic           issue;
    logic           first_term;
    logic           last_term;
    logic           final_out;
    logic           accept;
    logic [YW+1:0]  yi;
    logic [XW+1:0]  xi;
    logic           tap_pad;

    assign issue      = (state_q == StIssue);
    assign first_term = (ic_q == '0) && (ky_q == 2'd0) && (kx_q == 2'd0);
    assign last_term  = (ic_q == IcMax) && (ky_q == KMax) && (kx_q == KMax);
    assign final_out  = (y_q == YMax) && (x_q == XMax) && (oc_q == OcMax);
    assign accept     = out_valid_q && bus.out_ready;

    // Two extra bits: the top one flags a negative coordinate; since a coordinate never exceeds
    // the map size, the next one is set exactly when it lands at or past the far edge.
    assign yi      = {2'b00, y_q} + {{YW{1'b0}}, ky_q} - HalfY;
    assign xi      = {2'b00, x_q} + {{XW{1'b0}}, kx_q} - HalfX;
    assign tap_pad = yi[YW+1] | yi[YW] | xi[XW+1] | xi[XW];

    assign bus.int_mem_re  = issue;
    assign bus.input_addr  = issue ? {ic_q, yi[YW-1:0], xi[XW-1:0]} : '0;
    assign bus.kernel_addr = issue ? {ic_q, ky_q, kx_q, oc_q} : '0;
    assign bus.running     = running_q;
    assign bus.done        = done_q;
    assign bus.write_a     = s1_q;
    assign bus.write_b     = s1_q;
    assign bus.pad_zero    = pad1_q;
    assign bus.mac_valid   = mac_valid_q;
    assign bus.mac_accumulate_internal = acc_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.output_x    = out_x_q;
    assign bus.output_y    = out_y_q;
    assign bus.output_ch   = out_ch_q;

    always_ff @(posedge clk or posedge arst_in) begin
        if (arst_in) begin
            state_q     <= StIdle;
            y_q         <= '0;
            x_q         <= '0;
            oc_q        <= '0;
            ic_q        <= '0;
            ky_q        <= 2'd0;
            kx_q        <= 2'd0;
            out_x_q     <= '0;
            out_y_q     <= '0;
            out_ch_q    <= '0;
            running_q   <= 1'b0;
            done_q      <= 1'b0;
            s1_q        <= 1'b0;
            pad1_q      <= 1'b0;
            first1_q    <= 1'b0;
            last1_q     <= 1'b0;
            mac_valid_q <= 1'b0;
            acc_q       <= 1'b0;
            last2_q     <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            s1_q        <= issue;
            pad1_q      <= issue & tap_pad;
            first1_q    <= issue & first_term;
            last1_q     <= issue & last_term;
            mac_valid_q <= s1_q;
            acc_q       <= s1_q & ~first1_q;
            last2_q     <= last1_q;
            // The MAC result register is final one cycle after the last term enters it.
            if (last2_q) begin
                out_valid_q <= 1'b1;
            end else if (accept) begin
                out_valid_q <= 1'b0;
            end
            done_q <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        state_q   <= StIssue;
                        running_q <= 1'b1;
                    end
                end
                StIssue: begin
                    if (first_term) begin
                        out_x_q  <= x_q;
                        out_y_q  <= y_q;
                        out_ch_q <= oc_q;
                    end
                    if (kx_q == KMax) begin
                        kx_q <= 2'd0;
                        if (ky_q == KMax) begin
                            ky_q <= 2'd0;
                            ic_q <= (ic_q == IcMax) ? '0 : ic_q + ICW'(1);
                        end else begin
                            ky_q <= ky_q + 2'd1;
                        end
                    end else begin
                        kx_q <= kx_q + 2'd1;
                    end
                    if (last_term) begin
                        state_q <= StWaitOut;
                    end
                end
                StWaitOut: begin
                    // Holding here keeps the MAC accumulator intact until the consumer takes it.
                    if (accept) begin
                        if (final_out) begin
                            state_q   <= StDone;
                            running_q <= 1'b0;
                            done_q    <= 1'b1;
                            y_q       <= '0;
                            x_q       <= '0;
                            oc_q      <= '0;
                            out_x_q   <= '0;
                            out_y_q   <= '0;
                            out_ch_q  <= '0;
                        end else begin
                            state_q <= StIssue;
                            if (oc_q == OcMax) begin
                                oc_q <= '0;
                                if (x_q == XMax) begin
                                    x_q <= '0;
                                    y_q <= y_q + YW'(1);
                                end else begin
                                    x_q <= x_q + XW'(1);
                                end
                            end else begin
                                oc_q <= oc_q + OCW'(1);
                            end
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_conv_scheduler.sv
// Directed bench for conv_scheduler on a 4x4 map, 2 input / 2 output channels, 3x3 kernel.
module tb_conv_scheduler;
    localparam int W    = 4;
    localparam int H    = 4;
    localparam int IC   = 2;
    localparam int OC   = 2;
    localparam int K    = 3;
    localparam int N    = IC * K * K;
    localparam int NOUT = W * H * OC;
    localparam int PER  = N + 3;
    localparam int MAXC = 1024;

    logic clk = 1'b0;
    logic arst_in = 1'b1;
    always #5 clk = ~clk;

    conv_scheduler_if #(.XW(2), .YW(2), .ICW(1), .OCW(1)) bus ();

    conv_scheduler #(
        .FEATURE_MAP_WIDTH (W),
        .FEATURE_MAP_HEIGHT(H),
        .INPUT_NB_CHANNELS (IC),
        .OUTPUT_NB_CHANNELS(OC),
        .KERNEL_SIZE       (K)
    ) dut (
        .clk    (clk),
        .arst_in(arst_in),
        .bus    (bus)
    );

    logic [24:0] all_out;
    assign all_out = {bus.running, bus.done, bus.int_mem_re, bus.input_addr, bus.kernel_addr,
                      bus.write_a, bus.write_b, bus.pad_zero, bus.mac_valid,
                      bus.mac_accumulate_internal, bus.out_valid, bus.output_x, bus.output_y,
                      bus.output_ch};

    int checks = 0;
    int failures = 0;

    // Per-cycle record of one frame; cycle 0 is the first cycle after start is taken.
    logic       r_re  [MAXC];
    logic       r_wa  [MAXC];
    logic       r_wb  [MAXC];
    logic       r_pad [MAXC];
    logic       r_mv  [MAXC];
    logic       r_acc [MAXC];
    logic       r_ov  [MAXC];
    logic       r_rdy [MAXC];
    logic       r_done[MAXC];
    logic       r_run [MAXC];
    logic [4:0] r_ia  [MAXC];
    logic [5:0] r_ka  [MAXC];
    logic [1:0] r_ox  [MAXC];
    logic [1:0] r_oy  [MAXC];
    logic       r_och [MAXC];
    int acc_cyc[NOUT];
    int n_cyc, n_acc, n_done, done_cyc;

    function automatic int exp_y(input int k);  return k / (W * OC);  endfunction
    function automatic int exp_x(input int k);  return (k / OC) % W;  endfunction
    function automatic int exp_ch(input int k); return k % OC;        endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input int stall_idx, input int stall_len, input int pulse_cyc);
        int stall_ctr;
        int tail;
        stall_ctr = 0;
        tail = -1;
        n_cyc = 0;
        n_acc = 0;
        n_done = 0;
        done_cyc = -1;
        bus.out_ready = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        while (n_cyc < MAXC && tail != 0) begin
            bus.start = (n_cyc == pulse_cyc);
            if (bus.out_valid && n_acc == stall_idx && stall_ctr < stall_len) begin
                bus.out_ready = 1'b0;
                stall_ctr++;
            end else begin
                bus.out_ready = 1'b1;
            end
            r_re[n_cyc]   = bus.int_mem_re;
            r_wa[n_cyc]   = bus.write_a;
            r_wb[n_cyc]   = bus.write_b;
            r_pad[n_cyc]  = bus.pad_zero;
            r_mv[n_cyc]   = bus.mac_valid;
            r_acc[n_cyc]  = bus.mac_accumulate_internal;
            r_ov[n_cyc]   = bus.out_valid;
            r_rdy[n_cyc]  = bus.out_ready;
            r_done[n_cyc] = bus.done;
            r_run[n_cyc]  = bus.running;
            r_ia[n_cyc]   = bus.input_addr;
            r_ka[n_cyc]   = bus.kernel_addr;
            r_ox[n_cyc]   = bus.output_x;
            r_oy[n_cyc]   = bus.output_y;
            r_och[n_cyc]  = bus.output_ch;
            if (bus.out_valid && bus.out_ready) begin
                if (n_acc < NOUT) acc_cyc[n_acc] = n_cyc;
                n_acc++;
            end
            if (bus.done) begin
                n_done++;
                done_cyc = n_cyc;
                if (tail < 0) tail = 3;
            end
            if (tail > 0) tail--;
            tick();
            n_cyc++;
        end
        bus.start = 1'b0;
        bus.out_ready = 1'b1;
    endtask

    task automatic test_reset();
        int bad;
        bus.start = 1'b0;
        bus.out_ready = 1'b1;
        arst_in = 1'b1;
        repeat (2) tick();
        checks++;
        if (all_out !== 25'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=0", all_out);
        end
        arst_in = 1'b0;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (all_out !== 25'd0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL idle_quiet busy_cycles got=%0d exp=0", bad);
        end
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (4) tick();
        checks++;
        if (bus.int_mem_re !== 1'b1) begin
            failures++;
            $display("FAIL issuing_before_reset got=%b exp=1", bus.int_mem_re);
        end
        arst_in = 1'b1;
        #1;
        checks++;
        if (all_out !== 25'd0) begin
            failures++;
            $display("FAIL reset_mid_issue got=%h exp=0", all_out);
        end
        tick();
        arst_in = 1'b0;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (all_out !== 25'd0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL after_reset_idle busy_cycles got=%0d exp=0", bad);
        end
    endtask

    task automatic test_basic_count();
        int g, k, j, ic, ky, kx, yi, xi, lo, cnt, bad_acc, bad_addr, bad_pipe, bad_rise;
        logic [4:0] ea;
        logic [5:0] ek;
        logic p1, p2;
        int last_issue[NOUT];
        run_frame(-1, 0, -1);
        checks++;
        if (n_acc !== NOUT) begin
            failures++;
            $display("FAIL out_count got=%0d exp=%0d", n_acc, NOUT);
        end
        for (int q = 0; q < NOUT && q < n_acc; q++) begin
            checks++;
            if (acc_cyc[q] !== PER * q + PER - 1 || r_oy[acc_cyc[q]] !== 2'(exp_y(q)) ||
                r_ox[acc_cyc[q]] !== 2'(exp_x(q)) || r_och[acc_cyc[q]] !== 1'(exp_ch(q))) begin
                failures++;
                $display("FAIL output_%0d got cyc=%0d yxc=%0d,%0d,%0d exp cyc=%0d yxc=%0d,%0d,%0d",
                         q, acc_cyc[q], r_oy[acc_cyc[q]], r_ox[acc_cyc[q]], r_och[acc_cyc[q]],
                         PER * q + PER - 1, exp_y(q), exp_x(q), exp_ch(q));
            end
            lo = (q == 0) ? 0 : acc_cyc[q-1] + 1;
            cnt = 0;
            bad_acc = 0;
            for (int c = lo; c <= acc_cyc[q]; c++) begin
                if (r_mv[c]) begin
                    if (r_acc[c] !== (cnt != 0)) bad_acc++;
                    cnt++;
                end
            end
            checks++;
            if (cnt !== N || bad_acc !== 0) begin
                failures++;
                $display("FAIL mac_terms_%0d got terms=%0d bad_acc=%0d exp terms=%0d bad_acc=0",
                         q, cnt, bad_acc, N);
            end
        end
        g = 0;
        bad_addr = 0;
        bad_pipe = 0;
        for (int c = 0; c < n_cyc; c++) begin
            p1 = (c >= 1) ? r_re[c-1] : 1'b0;
            p2 = (c >= 2) ? r_re[c-2] : 1'b0;
            if (r_wa[c] !== p1 || r_wb[c] !== p1 || r_mv[c] !== p2) bad_pipe++;
            if (r_re[c] && g < NOUT * N) begin
                k = g / N;
                j = g % N;
                ic = j / (K * K);
                ky = (j % (K * K)) / K;
                kx = j % K;
                yi = exp_y(k) + ky - K / 2;
                xi = exp_x(k) + kx - K / 2;
                ea = 5'(ic * H * W + ((yi + H) % H) * W + (xi + W) % W);
                ek = 6'(((ic * 4 + ky) * 4 + kx) * OC + exp_ch(k));
                if (r_ia[c] !== ea || r_ka[c] !== ek) bad_addr++;
                if (j == N - 1) last_issue[k] = c;
            end
            if (r_re[c]) g++;
        end
        checks++;
        if (g !== NOUT * N || bad_addr !== 0) begin
            failures++;
            $display("FAIL addresses got issues=%0d bad=%0d exp issues=%0d bad=0",
                     g, bad_addr, NOUT * N);
        end
        checks++;
        if (bad_pipe !== 0) begin
            failures++;
            $display("FAIL pipeline_align bad_cycles got=%0d exp=0", bad_pipe);
        end
        bad_rise = 0;
        for (int q = 0; q < NOUT && g == NOUT * N; q++) begin
            if (r_ov[last_issue[q] + 3] !== 1'b1 || r_ov[last_issue[q] + 2] !== 1'b0) bad_rise++;
        end
        checks++;
        if (bad_rise !== 0) begin
            failures++;
            $display("FAIL out_valid_latency bad_outputs got=%0d exp=0", bad_rise);
        end
        checks++;
        if (n_done !== 1 || done_cyc !== PER * NOUT) begin
            failures++;
            $display("FAIL done_pulse got count=%0d cyc=%0d exp count=1 cyc=%0d",
                     n_done, done_cyc, PER * NOUT);
        end
        checks++;
        if (r_run[0] !== 1'b1 || done_cyc < 0 || r_run[done_cyc + 1] !== 1'b0) begin
            failures++;
            $display("FAIL running_window got start=%b after=%b exp start=1 after=0",
                     r_run[0], (done_cyc < 0) ? 1'bx : r_run[done_cyc + 1]);
        end
        checks++;
        if (all_out !== 25'd0) begin
            failures++;
            $display("FAIL idle_after_frame got=%h exp=0", all_out);
        end
    endtask

    task automatic test_padding();
        int g, k, j, ky, kx, bad;
        int pads[NOUT];
        logic ep;
        run_frame(-1, 0, -1);
        for (int q = 0; q < NOUT; q++) pads[q] = 0;
        g = 0;
        bad = 0;
        for (int c = 0; c + 1 < n_cyc; c++) begin
            if (r_re[c] && g < NOUT * N) begin
                k = g / N;
                j = g % N;
                ky = (j % (K * K)) / K;
                kx = j % K;
                if (r_pad[c+1] === 1'b1 && r_wa[c+1] === 1'b1) pads[k]++;
                if (k == 0) begin
                    ep = (ky == 0 || kx == 0);
                    if (r_pad[c+1] !== ep) bad++;
                end
                if (k == NOUT - 1) begin
                    ep = (ky == 2 || kx == 2);
                    if (r_pad[c+1] !== ep) bad++;
                end
                g++;
            end
        end
        checks++;
        if (pads[0] !== 10 || pads[1] !== 10) begin
            failures++;
            $display("FAIL pad_count_00 got=%0d,%0d exp=10,10", pads[0], pads[1]);
        end
        checks++;
        if (pads[NOUT-2] !== 10 || pads[NOUT-1] !== 10) begin
            failures++;
            $display("FAIL pad_count_33 got=%0d,%0d exp=10,10", pads[NOUT-2], pads[NOUT-1]);
        end
        checks++;
        if (pads[10] !== 0 || pads[11] !== 0) begin
            failures++;
            $display("FAIL pad_count_11 got=%0d,%0d exp=0,0", pads[10], pads[11]);
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL pad_taps bad_taps got=%0d exp=0", bad);
        end
    endtask

    task automatic test_backpressure();
        int stall, bad, bad_seq, ecyc;
        run_frame(4, 20, -1);
        stall = 0;
        bad = 0;
        for (int c = 0; c < n_cyc; c++) begin
            if (r_ov[c] && !r_rdy[c]) begin
                stall++;
                if (r_oy[c] !== 2'd0 || r_ox[c] !== 2'd2 || r_och[c] !== 1'b0 ||
                    r_re[c] !== 1'b0 || r_mv[c] !== 1'b0) bad++;
            end
        end
        checks++;
        if (stall !== 20 || bad !== 0) begin
            failures++;
            $display("FAIL stall_window got len=%0d bad=%0d exp len=20 bad=0", stall, bad);
        end
        bad_seq = 0;
        for (int q = 0; q < NOUT && q < n_acc; q++) begin
            ecyc = PER * q + PER - 1 + ((q >= 4) ? 20 : 0);
            if (acc_cyc[q] !== ecyc || r_oy[acc_cyc[q]] !== 2'(exp_y(q)) ||
                r_ox[acc_cyc[q]] !== 2'(exp_x(q)) || r_och[acc_cyc[q]] !== 1'(exp_ch(q)))
                bad_seq++;
        end
        checks++;
        if (n_acc !== NOUT || bad_seq !== 0) begin
            failures++;
            $display("FAIL stall_sequence got count=%0d bad=%0d exp count=%0d bad=0",
                     n_acc, bad_seq, NOUT);
        end
        checks++;
        if (n_acc < 5 || acc_cyc[4] !== 124 || r_re[125] !== 1'b1 || r_re[124] !== 1'b0) begin
            failures++;
            $display("FAIL resume_after_accept got acc=%0d re=%b%b exp acc=124 re=01",
                     (n_acc < 5) ? -1 : acc_cyc[4], r_re[124], r_re[125]);
        end
        checks++;
        if (n_done !== 1 || done_cyc !== PER * NOUT + 20) begin
            failures++;
            $display("FAIL stall_done got count=%0d cyc=%0d exp count=1 cyc=%0d",
                     n_done, done_cyc, PER * NOUT + 20);
        end
    endtask

    task automatic test_ignored_start();
        int bad_seq, bad_run;
        run_frame(-1, 0, 5);
        bad_seq = 0;
        for (int q = 0; q < NOUT && q < n_acc; q++) begin
            if (acc_cyc[q] !== PER * q + PER - 1 || r_oy[acc_cyc[q]] !== 2'(exp_y(q)) ||
                r_ox[acc_cyc[q]] !== 2'(exp_x(q)) || r_och[acc_cyc[q]] !== 1'(exp_ch(q)))
                bad_seq++;
        end
        checks++;
        if (n_acc !== NOUT || bad_seq !== 0) begin
            failures++;
            $display("FAIL ignored_start_sequence got count=%0d bad=%0d exp count=%0d bad=0",
                     n_acc, bad_seq, NOUT);
        end
        bad_run = 0;
        for (int c = 0; c < PER * NOUT && c < n_cyc; c++) begin
            if (r_run[c] !== 1'b1) bad_run++;
        end
        checks++;
        if (n_done !== 1 || done_cyc !== PER * NOUT || bad_run !== 0) begin
            failures++;
            $display("FAIL ignored_start_done got count=%0d cyc=%0d gaps=%0d exp count=1 cyc=%0d gaps=0",
                     n_done, done_cyc, bad_run, PER * NOUT);
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.out_ready = 1'b1;
        test_reset();
        test_basic_count();
        test_padding();
        test_backpressure();
        test_ignored_start();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
